weightmemory_loader: RTL and testbench

//   Upstream feeder of the weight-memory SRAM bank. Accepts a stream of ternary weights, five trits per beat.

---
 rtl/cutie_weight_pkg.sv | 41 ++++
 rtl/weightmemory_loader_encoder.sv | 27 ++
 rtl/weightmemory_loader.sv | 181 ++++++++++++++++++
 tb/tb_weightmemory_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cutie_weight_pkg.sv
// Shared types, trit codes and derived widths for the weight-memory loader.
// Optional readback verify is enabled by WEIGHTMEMORY_LOADER_READBACK_EN.
package cutie_weight_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_POS  = 2'b01;
  localparam trit_t TRIT_NEG  = 2'b11;

  localparam int TRITS_PER_BEAT = 5;
  localparam int BITS_PER_GROUP = 8;

  function automatic int eff_trits(int n_i, int stagger);
    return n_i / stagger;
  endfunction

  function automatic int phys_trits(int n_i, int stagger);
    return ((eff_trits(n_i, stagger) + TRITS_PER_BEAT - 1)
            / TRITS_PER_BEAT) * TRITS_PER_BEAT;
  endfunction

  function automatic int numdec(int n_i, int stagger);
    return phys_trits(n_i, stagger) / TRITS_PER_BEAT;
  endfunction

  function automatic int pbw(int n_i, int stagger);
    return numdec(n_i, stagger) * BITS_PER_GROUP;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
    S_VERIFY,
`endif
    S_DONE
  } loader_state_e;

endpackage

// File: rtl/weightmemory_loader_encoder.sv
// Packs five trits into one byte as a base-3 number (0->0, +1->1, -1->2),
// trit 0 least significant; the all-zero group encodes to 8'h00.
module weightmemory_loader_encoder
  import cutie_weight_pkg::*;
(
  input  trit_t [4:0] trits_i,
  output logic  [7:0] code_o
);

  logic [7:0] acc;
  logic [1:0] dig;

  always_comb begin
    acc = 8'd0;
    dig = 2'd0;
    for (int j = 4; j >= 0; j--) begin
      unique case (trits_i[j])
        TRIT_POS: dig = 2'd1;
        TRIT_NEG: dig = 2'd2;
        default:  dig = 2'd0;
      endcase
      acc = acc * 8'd3 + {6'd0, dig};
    end
    code_o = acc;
  end

endmodule

// File: rtl/weightmemory_loader.sv
// Streams ternary beats into packed words and writes them to the weight bank.
// WEIGHTMEMORY_LOADER_READBACK_EN adds a read-back compare after each write.
module weightmemory_loader
  import cutie_weight_pkg::*;
#(
  parameter  int N_I            = 512,
  parameter  int WEIGHT_STAGGER = 8,
  parameter  int BANKDEPTH      = 90,
  localparam int AW             = $clog2(BANKDEPTH),
  localparam int EFF            = eff_trits(N_I, WEIGHT_STAGGER),
  localparam int NUMDEC         = numdec(N_I, WEIGHT_STAGGER),
  localparam int PBW            = pbw(N_I, WEIGHT_STAGGER)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_start_i,
  input  logic [AW-1:0]     cfg_base_addr_i,
  input  logic [AW:0]       cfg_num_words_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  trit_t [4:0]       in_trits_i,
  input  logic              mem_read_busy_i,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [PBW-1:0]    mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
  input  logic [PBW-1:0]    mem_rdata_i,
  output logic              mem_re_o,
`endif
  output logic              mismatch_o
);

  localparam int BW = $clog2(NUMDEC + 1);

  loader_state_e  state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW:0]    count_q, count_d;
  logic [AW:0]    wdone_q, wdone_d;
  logic [PBW-1:0] word_q, word_d;

  trit_t [4:0]    beat_trits;
  logic [7:0]     beat_code;
  logic [AW-1:0]  addr_nxt;
  logic [AW:0]    wdone_nxt;

  // Trits past the effective vector length are padding and must read as 0.
  always_comb begin
    for (int j = 0; j < 5; j++) begin
      if (5 * int'(beat_q) + j >= EFF) beat_trits[j] = TRIT_ZERO;
      else                             beat_trits[j] = in_trits_i[j];
    end
  end

  weightmemory_loader_encoder u_enc (
    .trits_i (beat_trits),
    .code_o  (beat_code)
  );

  assign addr_nxt  = (addr_q == AW'(BANKDEPTH - 1)) ? '0 : addr_q + 1'b1;
  assign wdone_nxt = wdone_q + 1'b1;

`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
  logic rd_pend_q, rd_pend_d;
  logic mism_q, mism_d;
  assign mismatch_o = mism_q;
`else
  assign mismatch_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wdone_d    = wdone_q;
    word_d     = word_q;
    in_ready_o = 1'b0;
    mem_we_o   = 1'b0;
    done_o     = 1'b0;
`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
    rd_pend_d  = rd_pend_q;
    mism_d     = mism_q;
    mem_re_o   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          addr_d  = cfg_base_addr_i;
          count_d = cfg_num_words_i;
          wdone_d = '0;
          beat_d  = '0;
`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
          mism_d  = 1'b0;
`endif
          state_d = (cfg_num_words_i == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          word_d[8*int'(beat_q) +: 8] = beat_code;
          if (beat_q == BW'(NUMDEC - 1)) begin
            beat_d  = '0;
            state_d = S_WRITE;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (!mem_read_busy_i) begin
          mem_we_o = 1'b1;
`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
          rd_pend_d = 1'b0;
          state_d   = S_VERIFY;
`else
          addr_d  = addr_nxt;
          wdone_d = wdone_nxt;
          state_d = (wdone_nxt == count_q) ? S_DONE : S_FILL;
`endif
        end
      end
`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
      // Address holds on the written word until its read data is compared.
      S_VERIFY: begin
        if (!rd_pend_q) begin
          if (!mem_read_busy_i) begin
            mem_re_o  = 1'b1;
            rd_pend_d = 1'b1;
          end
        end else begin
          if (mem_rdata_i != word_q) mism_d = 1'b1;
          rd_pend_d = 1'b0;
          addr_d    = addr_nxt;
          wdone_d   = wdone_nxt;
          state_d   = (wdone_nxt == count_q) ? S_DONE : S_FILL;
        end
      end
`endif
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      wdone_q   <= '0;
      word_q    <= '0;
`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
      rd_pend_q <= 1'b0;
      mism_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      wdone_q   <= wdone_d;
      word_q    <= word_d;
`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
      rd_pend_q <= rd_pend_d;
      mism_q    <= mism_d;
`endif
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = word_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_weightmemory_loader.sv
// Directed bench for weightmemory_loader: a bank-side model decodes every
// write and checks it against the trits the bench sent.
module tb_weightmemory_loader;

  localparam int AW  = 7;
  localparam int PBW = 104;
  localparam int PT  = 65;

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic           cfg_start_i = 1'b0;
  logic [AW-1:0]  cfg_base_addr_i = '0;
  logic [AW:0]    cfg_num_words_i = '0;
  logic           in_valid_i = 1'b0;
  logic           in_ready_o;
  logic [4:0][1:0] in_trits_i = '0;
  logic           mem_read_busy_i = 1'b0;
  logic           mem_we_o;
  logic [AW-1:0]  mem_addr_o;
  logic [PBW-1:0] mem_wdata_o;
  logic           busy_o;
  logic           done_o;
  logic           mismatch_o;
`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
  logic [PBW-1:0] mem_rdata_i = '0;
  logic           mem_re_o;
  logic [PBW-1:0] bank [90];
  int             rd_cnt = 0;
  logic           corrupt_first = 1'b0;
`endif

  weightmemory_loader dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .cfg_start_i     (cfg_start_i),
    .cfg_base_addr_i (cfg_base_addr_i),
    .cfg_num_words_i (cfg_num_words_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_trits_i      (in_trits_i),
    .mem_read_busy_i (mem_read_busy_i),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
    .mem_rdata_i     (mem_rdata_i),
    .mem_re_o        (mem_re_o),
`endif
    .mismatch_o      (mismatch_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [2*PT-1:0] tv;
  } exp_t;

  exp_t           expq[$];
  logic [PBW-1:0] wlog[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bank-side decoder: each byte is a base-3 number of five trits.
  function automatic logic [2*PT-1:0] decode(input logic [PBW-1:0] w);
    logic [2*PT-1:0] tv;
    int b, d;
    tv = '0;
    for (int n = 0; n < 13; n++) begin
      b = int'(w[8*n +: 8]);
      for (int j = 0; j < 5; j++) begin
        d = b % 3;
        b = b / 3;
        tv[2*(5*n+j) +: 2] = (d == 0) ? 2'b00 : (d == 1) ? 2'b01 :
                             (d == 2) ? 2'b11 : 2'b10;
      end
    end
    return tv;
  endfunction

  always @(negedge clk) begin
    if (!rst_i && mem_we_o) begin
      exp_t e;
      chk("we_qualified", {mem_read_busy_i, in_ready_o}, 0);
      wlog.push_back(mem_wdata_o);
      if (expq.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("write_addr", mem_addr_o, e.addr);
        chk("write_trits", decode(mem_wdata_o), e.tv);
      end
    end
  end

`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
  always @(posedge clk) begin
    if (mem_we_o) bank[mem_addr_o] <= mem_wdata_o;
    if (mem_re_o) begin
      mem_rdata_i <= bank[mem_addr_o] ^
                     PBW'((corrupt_first && rd_cnt == 0) ? 1 : 0);
      rd_cnt <= rd_cnt + 1;
    end
  end
`endif

  task automatic start(input int base, input int cnt);
    cfg_start_i     = 1'b1;
    cfg_base_addr_i = AW'(base);
    cfg_num_words_i = (AW+1)'(cnt);
    @(posedge clk); #1;
    cfg_start_i = 1'b0;
  endtask

  task automatic send_beat(input logic [9:0] t);
    bit ok;
    ok = 1'b0;
    in_valid_i = 1'b1;
    in_trits_i = t;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready_o;
    end
    if (!ok) chk("beat_handshake_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic send_word(input int a, input logic [2*PT-1:0] raw,
                           input bit stall_last);
    exp_t e;
    logic [1:0] t;
    e.addr = AW'(a);
    for (int k = 0; k < PT; k++) begin
      t = raw[2*k +: 2];
      e.tv[2*k +: 2] = (k >= 64 || t == 2'b10) ? 2'b00 : t;
    end
    expq.push_back(e);
    for (int b = 0; b < 13; b++) begin
      if (b == 12 && stall_last) mem_read_busy_i = 1'b1;
      send_beat(raw[10*b +: 10]);
    end
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = done_o;
    end
    chk({nm, "_done_seen"}, ok, 1);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, {done_o, busy_o}, 0);
    chk({nm, "_all_writes"}, expq.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [2*PT-1:0] rnd_word();
    logic [2*PT-1:0] r;
    for (int k = 0; k < PT; k++) r[2*k +: 2] = 2'($urandom_range(0, 3));
    r[2*64 +: 2] = 2'b01;
    return r;
  endfunction

  logic [2*PT-1:0] all_pos, all_neg;
  logic [PBW-1:0]  w;
  logic [PBW-1:0]  zero_w;
  int nwr;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    zero_w = '0;
    for (int k = 0; k < PT; k++) begin
      all_pos[2*k +: 2] = 2'b01;
      all_neg[2*k +: 2] = 2'b11;
    end
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {in_ready_o, mem_we_o, done_o, mismatch_o, busy_o,
         mem_addr_o, mem_wdata_o}, 0);
    @(posedge clk); #1;

    // 1: single all-zero word at 0
    start(0, 1);
    send_word(0, '0, 1'b0);
    wait_done("t1");
    w = wlog.pop_back();
    chk("t1_zero_word", w, zero_w);

    // count of zero goes straight to done
    nwr = wlog.size();
    start(7, 0);
    wait_done("t0");
    chk("t0_no_write", wlog.size(), nwr);

    // literal pins: all +1 and all -1 words
    start(3, 2);
    send_word(3, all_pos, 1'b0);
    send_word(4, all_neg, 1'b0);
    wait_done("tpin");
    w = wlog.pop_back();
    chk("pin_neg_byte0", w[7:0], 8'd242);
    chk("pin_neg_byte12", w[103:96], 8'd80);
    w = wlog.pop_back();
    chk("pin_pos_byte0", w[7:0], 8'd121);
    chk("pin_pos_byte12", w[103:96], 8'd40);

    // 2: random words, padding trit driven +1
    start(5, 3);
    for (int i = 0; i < 3; i++) send_word(5 + i, rnd_word(), 1'b0);
    wait_done("t2");

    // 3: address wrap
    start(89, 2);
    send_word(89, rnd_word(), 1'b0);
    send_word(0, rnd_word(), 1'b0);
    wait_done("t3");

    // 4: bank read busy for four cycles in WRITE
    start(40, 1);
    send_word(40, rnd_word(), 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t4_stall", {mem_we_o, in_ready_o, busy_o}, 3'b001);
      @(posedge clk); #1;
    end
    mem_read_busy_i = 1'b0;
    wait_done("t4");

    // 5: reset in the middle of word 2
    start(10, 3);
    send_word(10, rnd_word(), 1'b0);
    for (int b = 0; b < 6; b++) send_beat(10'(b * 37));
    nwr = wlog.size();
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("t5_reset_outputs",
        {in_ready_o, mem_we_o, done_o, mismatch_o, busy_o,
         mem_addr_o, mem_wdata_o}, 0);
    repeat (3) @(negedge clk);
    chk("t5_no_more_write", wlog.size(), nwr);
    chk("t5_idle", busy_o, 0);
    @(posedge clk); #1;
    start(20, 1);
    send_word(20, rnd_word(), 1'b0);
    wait_done("t5b");

`ifdef WEIGHTMEMORY_LOADER_READBACK_EN
    // 6: corrupted readback of word 1 of 2
    rd_cnt = 0;
    corrupt_first = 1'b1;
    start(30, 2);
    send_word(30, rnd_word(), 1'b0);
    send_word(31, rnd_word(), 1'b0);
    begin
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
        @(negedge clk);
        ok = done_o;
      end
      chk("t6_done_seen", ok, 1);
      chk("t6_mismatch_at_done", mismatch_o, 1);
    end
    @(posedge clk); #1;
    corrupt_first = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
